pc_control_unit: RTL and testbench

- Parametrised successor to the linear program counter in the single-cycle core.
- Adds:
  - stall;
  - branch/jump redirect with alignment checking;
  - a run/halt/trap state machine driven by the decoder's 2-bit debug code;
  - a retired-instruction counter.
- Sits between Decode/ALU (redirect, debug) and InstructionMemory (pc_address). It replaces the breakpoint/illegal handling the bench currently does in simulation-only code.

---
 rtl/pc_ctrl_pkg.sv | 20 ++
 rtl/retire_counter.sv | 24 ++
 rtl/pc_control_unit.sv | 108 ++++++++++
 tb/tb_pc_control_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the program-counter control unit and the decoder.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_e;

    // Decoder debug codes (2'b11 is reserved and treated as none)
    localparam logic [1:0] DBG_NONE    = 2'b00;
    localparam logic [1:0] DBG_BREAK   = 2'b01;
    localparam logic [1:0] DBG_ILLEGAL = 2'b10;

    // Trap causes reported on trap_cause
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

endpackage

// File: rtl/retire_counter.sv
// Free-running event counter; wraps silently modulo 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count one per cycle with inc high; reset clears to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_control_unit.sv
// Program counter with stall, checked redirect, run/halt/trap control and a
// retired-instruction counter. Every output comes from registered state.
module pc_control_unit
    import pc_ctrl_pkg::*;
#(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                STEP         = 4,
    parameter int                CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic [1:0]       debug,
    input  logic             resume,
    output logic [XLEN-1:0]  pc_address,
    output logic             running,
    output logic             halted,
    output logic             trapped,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired_count
);

    // STEP is a power of two, so the low bits select misalignment
    localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      cause_q, cause_d;
    logic            retire;
    logic            misaligned;

    assign misaligned = (redirect_target & ALIGN_MASK) != '0;

    // Next state, next pc and retire strobe; priority debug > stall > redirect
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        retire  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (debug == DBG_BREAK) begin
                    state_d = ST_HALT;
                end else if (debug == DBG_ILLEGAL) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (stall) begin
                    // hold; a stalled redirect is re-presented by its producer
                    state_d = ST_RUN;
                end else if (redirect_valid && misaligned) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MISALIGN;
                end else if (redirect_valid) begin
                    pc_d   = redirect_target;
                    retire = 1'b1;
                end else begin
                    pc_d   = pc_q + STEP_X;
                    retire = 1'b1;
                end
            end
            ST_HALT: begin
                // the breakpoint instruction completes and is skipped on resume
                if (resume) begin
                    state_d = ST_RUN;
                    pc_d    = pc_q + STEP_X;
                    retire  = 1'b1;
                end
            end
            default: begin
                // trap is absorbing until reset
                state_d = state_q;
            end
        endcase
    end

    // State, pc and cause registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (retire),
        .count (retired_count)
    );

    assign pc_address = pc_q;
    assign running    = (state_q == ST_RUN);
    assign halted     = (state_q == ST_HALT);
    assign trapped    = (state_q == ST_TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Bench for pc_control_unit: a 32-bit instance driven from a vector table and
// an 8-bit/3-bit-counter instance exercising pc and counter wrap.
module tb_pc_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: XLEN=32, RESET_VECTOR=0x100
    logic        reset, stall, redirect_valid, resume;
    logic [31:0] redirect_target;
    logic [1:0]  debug;
    logic [31:0] pc_address;
    logic        running, halted, trapped;
    logic [1:0]  trap_cause;
    logic [31:0] retired_count;

    pc_control_unit #(
        .XLEN(32), .RESET_VECTOR(32'h100), .STEP(4), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .debug(debug), .resume(resume), .pc_address(pc_address),
        .running(running), .halted(halted), .trapped(trapped),
        .trap_cause(trap_cause), .retired_count(retired_count)
    );

    // Narrow instance: XLEN=8, start 0xF0, CNT_W=3
    logic       s_reset;
    logic [7:0] s_pc;
    logic       s_running, s_halted, s_trapped;
    logic [1:0] s_cause;
    logic [2:0] s_cnt;

    pc_control_unit #(
        .XLEN(8), .RESET_VECTOR(8'hF0), .STEP(4), .CNT_W(3)
    ) dut_small (
        .clk(clk), .reset(s_reset), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_target(8'h00),
        .debug(2'b00), .resume(1'b0), .pc_address(s_pc),
        .running(s_running), .halted(s_halted), .trapped(s_trapped),
        .trap_cause(s_cause), .retired_count(s_cnt)
    );

    // flags are {trapped, halted, running}
    localparam logic [2:0] F_RUN  = 3'b001;
    localparam logic [2:0] F_HALT = 3'b010;
    localparam logic [2:0] F_TRAP = 3'b100;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rv;
        logic [31:0] tgt;
        logic [1:0]  dbg;
        logic        res;
        logic [31:0] e_pc;
        logic [2:0]  e_fl;
        logic [1:0]  e_cause;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  fl;
        logic [1:0]  cause;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic rst, input logic stl, input logic rv,
                                input logic [31:0] tgt, input logic [1:0] dbg,
                                input logic res, input logic [31:0] e_pc,
                                input logic [2:0] e_fl, input logic [1:0] e_cause,
                                input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rv = rv; v.tgt = tgt; v.dbg = dbg; v.res = res;
        v.e_pc = e_pc; v.e_fl = e_fl; v.e_cause = e_cause; v.e_cnt = e_cnt;
        return v;
    endfunction

    // Pop the oldest expectation and compare it with the sampled outputs
    task automatic check(input string name, input logic [31:0] a_pc,
                         input logic [2:0] a_fl, input logic [1:0] a_cause,
                         input logic [31:0] a_cnt);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (a_pc !== e.pc) begin
            n_err++;
            $display("FAIL %s pc got %h want %h", name, a_pc, e.pc);
        end
        if (a_fl !== e.fl) begin
            n_err++;
            $display("FAIL %s {trapped,halted,running} got %b want %b", name, a_fl, e.fl);
        end
        if (a_cause !== e.cause) begin
            n_err++;
            $display("FAIL %s trap_cause got %b want %b", name, a_cause, e.cause);
        end
        if (a_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s retired_count got %0d want %0d", name, a_cnt, e.cnt);
        end
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; debug = 2'b00; resume = 1'b0;
        s_reset = 1'b1;

        //           rst stl rv  tgt           dbg    res  pc            flags   cause  cnt
        vecs.push_back(mk(1, 0, 0, 32'h0,        2'b00, 0, 32'h100,      F_RUN,  2'b00, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 0, 32'h104,      F_RUN,  2'b00, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 0, 32'h108,      F_RUN,  2'b00, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 0, 32'h10C,      F_RUN,  2'b00, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 0, 32'h110,      F_RUN,  2'b00, 4));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 0, 32'h114,      F_RUN,  2'b00, 5));
        vecs.push_back(mk(0, 0, 1, 32'h8,        2'b00, 0, 32'h8,        F_RUN,  2'b00, 6));
        vecs.push_back(mk(0, 1, 0, 32'h0,        2'b00, 0, 32'h8,        F_RUN,  2'b00, 6));
        vecs.push_back(mk(0, 1, 1, 32'h50,       2'b00, 0, 32'h8,        F_RUN,  2'b00, 6));
        vecs.push_back(mk(0, 1, 1, 32'h2,        2'b00, 0, 32'h8,        F_RUN,  2'b00, 6));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 0, 32'hC,        F_RUN,  2'b00, 7));
        vecs.push_back(mk(0, 0, 1, 32'h10,       2'b00, 0, 32'h10,       F_RUN,  2'b00, 8));
        vecs.push_back(mk(0, 0, 1, 32'h40,       2'b00, 0, 32'h40,       F_RUN,  2'b00, 9));
        vecs.push_back(mk(0, 0, 1, 32'h42,       2'b00, 0, 32'h40,       F_TRAP, 2'b10, 9));
        vecs.push_back(mk(0, 0, 1, 32'h80,       2'b00, 1, 32'h40,       F_TRAP, 2'b10, 9));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 0, 32'h40,       F_TRAP, 2'b10, 9));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b01, 0, 32'h40,       F_TRAP, 2'b10, 9));
        vecs.push_back(mk(1, 0, 0, 32'h0,        2'b00, 0, 32'h100,      F_RUN,  2'b00, 0));
        vecs.push_back(mk(0, 0, 1, 32'h20,       2'b00, 0, 32'h20,       F_RUN,  2'b00, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b01, 0, 32'h20,       F_HALT, 2'b00, 1));
        vecs.push_back(mk(0, 0, 1, 32'h60,       2'b00, 0, 32'h20,       F_HALT, 2'b00, 1));
        vecs.push_back(mk(0, 1, 1, 32'h60,       2'b00, 0, 32'h20,       F_HALT, 2'b00, 1));
        vecs.push_back(mk(0, 0, 1, 32'h61,       2'b10, 0, 32'h20,       F_HALT, 2'b00, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b01, 0, 32'h20,       F_HALT, 2'b00, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 1, 32'h24,       F_RUN,  2'b00, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 1, 32'h28,       F_RUN,  2'b00, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b11, 0, 32'h2C,       F_RUN,  2'b00, 4));
        vecs.push_back(mk(0, 0, 1, 32'h30,       2'b00, 0, 32'h30,       F_RUN,  2'b00, 5));
        vecs.push_back(mk(0, 1, 1, 32'h44,       2'b10, 0, 32'h30,       F_TRAP, 2'b01, 5));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 1, 32'h30,       F_TRAP, 2'b01, 5));
        vecs.push_back(mk(1, 0, 1, 32'h44,       2'b01, 0, 32'h100,      F_RUN,  2'b00, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        2'b01, 0, 32'h100,      F_HALT, 2'b00, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b10, 1, 32'h104,      F_RUN,  2'b00, 1));
        vecs.push_back(mk(0, 1, 1, 32'h101,      2'b00, 0, 32'h104,      F_RUN,  2'b00, 1));
        vecs.push_back(mk(0, 0, 1, 32'h103,      2'b00, 0, 32'h104,      F_TRAP, 2'b10, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        2'b00, 0, 32'h100,      F_RUN,  2'b00, 0));
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 2'b00, 0, 32'hFFFFFFFC, F_RUN,  2'b00, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        2'b00, 0, 32'h0,        F_RUN,  2'b00, 2));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset           = vecs[i].rst;
            stall           = vecs[i].stl;
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].tgt;
            debug           = vecs[i].dbg;
            resume          = vecs[i].res;
            e.pc = vecs[i].e_pc; e.fl = vecs[i].e_fl;
            e.cause = vecs[i].e_cause; e.cnt = vecs[i].e_cnt;
            sb.push_back(e);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), pc_address, {trapped, halted, running},
                  trap_cause, retired_count);
        end

        // Narrow instance: reset, then nine sequential retires across the pc wrap
        s_reset = 1'b1;
        e.pc = 32'hF0; e.fl = F_RUN; e.cause = 2'b00; e.cnt = 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check("wrap_reset", {24'h0, s_pc}, {s_trapped, s_halted, s_running},
              s_cause, {29'h0, s_cnt});
        s_reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] epc;
            logic [2:0] ecnt;
            epc  = 8'(8'hF0 + 4 * i);
            ecnt = 3'(i);
            e.pc = {24'h0, epc}; e.fl = F_RUN; e.cause = 2'b00; e.cnt = {29'h0, ecnt};
            sb.push_back(e);
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d", i), {24'h0, s_pc}, {s_trapped, s_halted, s_running},
                  s_cause, {29'h0, s_cnt});
        end

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
